// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester, response and data-memory signals of the two-port memory arbiter
interface memory_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6
);
  // Requester command side
  logic                     ReqValid0;
  logic                     ReqValid1;
  logic                     ReqWrite0;
  logic                     ReqWrite1;
  logic [ADDRESS_WIDTH-1:0] ReqAddress0;
  logic [ADDRESS_WIDTH-1:0] ReqAddress1;
  logic [DATA_WIDTH-1:0]    ReqWriteData0;
  logic [DATA_WIDTH-1:0]    ReqWriteData1;
  logic                     ReqReady0;
  logic                     ReqReady1;

  // Response side, read data shared by both requesters
  logic                     RespValid0;
  logic                     RespValid1;
  logic [DATA_WIDTH-1:0]    RespReadData;
  logic                     Grant;
  logic                     Busy;

  // Data-memory port
  logic [ADDRESS_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0]    MemWriteData;
  logic                     MemRead;
  logic                     MemWrite;
  logic [DATA_WIDTH-1:0]    MemReadData;

  modport slave (
    input  ReqValid0, ReqValid1, ReqWrite0, ReqWrite1,
    input  ReqAddress0, ReqAddress1, ReqWriteData0, ReqWriteData1,
    input  MemReadData,
    output ReqReady0, ReqReady1, RespValid0, RespValid1, RespReadData,
    output Grant, Busy,
    output MemAddress, MemWriteData, MemRead, MemWrite
  );

  modport master (
    output ReqValid0, ReqValid1, ReqWrite0, ReqWrite1,
    output ReqAddress0, ReqAddress1, ReqWriteData0, ReqWriteData1,
    output MemReadData,
    input  ReqReady0, ReqReady1, RespValid0, RespValid1, RespReadData,
    input  Grant, Busy,
    input  MemAddress, MemWriteData, MemRead, MemWrite
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one data-memory port between two requesters
module memory_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 6
) (
  input  logic             Clock,
  input  logic             ResetN,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic                     grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic                     winner;

  // Tie goes to the requester that did not win last; a lone requester always wins
  always_comb begin
    winner = 1'b0;
    if (bus.ReqValid0 && bus.ReqValid1) begin
      winner = ~last_grant_q;
    end else begin
      winner = bus.ReqValid1;
    end
  end

  // State and captured command; last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state, command capture in IDLE only, and all outputs decoded from the state
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wdata_d           = wdata_q;
    write_d           = write_q;
    grant_d           = grant_q;
    last_grant_d      = last_grant_q;
    bus.MemAddress    = '0;
    bus.MemWriteData  = '0;
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.ReqReady0     = 1'b0;
    bus.ReqReady1     = 1'b0;
    bus.RespValid0    = 1'b0;
    bus.RespValid1    = 1'b0;
    bus.RespReadData  = '0;

    case (state_q)
      IDLE: begin
        if (bus.ReqValid0 || bus.ReqValid1) begin
          state_d      = ISSUE;
          grant_d      = winner;
          last_grant_d = winner;
          addr_d       = winner ? bus.ReqAddress1   : bus.ReqAddress0;
          wdata_d      = winner ? bus.ReqWriteData1 : bus.ReqWriteData0;
          write_d      = winner ? bus.ReqWrite1     : bus.ReqWrite0;
        end
      end
      ISSUE: begin
        state_d          = RESP;
        bus.MemAddress   = addr_q;
        bus.MemWriteData = wdata_q;
        bus.MemRead      = ~write_q;
        bus.MemWrite     = write_q;
        bus.ReqReady0    = ~grant_q;
        bus.ReqReady1    = grant_q;
      end
      RESP: begin
        state_d          = IDLE;
        bus.RespValid0   = ~grant_q;
        bus.RespValid1   = grant_q;
        bus.RespReadData = write_q ? '0 : bus.MemReadData;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Grant = grant_q;
  assign bus.Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed scoreboard bench for the two-port memory arbiter
module tb_memory_arbiter;

  logic Clock;
  logic ResetN;

  memory_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) bus ();

  memory_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(6)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Requester drive registers
  logic        rv [2];
  logic        rw [2];
  logic [5:0]  ra [2];
  logic [31:0] rd [2];

  assign bus.ReqValid0     = rv[0];
  assign bus.ReqValid1     = rv[1];
  assign bus.ReqWrite0     = rw[0];
  assign bus.ReqWrite1     = rw[1];
  assign bus.ReqAddress0   = ra[0];
  assign bus.ReqAddress1   = ra[1];
  assign bus.ReqWriteData0 = rd[0];
  assign bus.ReqWriteData1 = rd[1];

  // Data memory model with a registered read port
  logic [31:0] mem [64];
  logic [31:0] mem_rdata;
  bit          mem_init_done;

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  always @(posedge Clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else begin
      if (bus.MemWrite) mem[bus.MemAddress] <= bus.MemWriteData;
      if (bus.MemRead)  mem_rdata <= mem[bus.MemAddress];
    end
  end

  assign bus.MemReadData = mem_rdata;

  // Scoreboard state
  int          n_vec;
  int          n_bad;
  int          cyc;
  logic [31:0] shadow [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          ready_cnt [2];
  int          ready_cyc [2];
  int          resp_cnt  [2];
  int          resp_cyc  [2];
  int          order [$];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response for the command requester i presents at the moment it is accepted
  task automatic push_exp(input int i);
    logic [31:0] v;
    if (rw[i]) begin
      v = 32'h0;
      shadow[ra[i]] = rd[i];
    end else begin
      v = shadow[ra[i]];
    end
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Response checker and protocol invariants, every cycle outside reset
  always @(negedge Clock) begin
    if (ResetN) begin
      if (bus.RespValid0) begin
        resp_cnt[0]++;
        resp_cyc[0] = cyc;
        if (q0.size() == 0) chk("resp0_unexpected", 32'd1, 32'd0);
        else                chk("rdata0", bus.RespReadData, q0.pop_front());
      end
      if (bus.RespValid1) begin
        resp_cnt[1]++;
        resp_cyc[1] = cyc;
        if (q1.size() == 0) chk("resp1_unexpected", 32'd1, 32'd0);
        else                chk("rdata1", bus.RespReadData, q1.pop_front());
      end
      if (!bus.RespValid0 && !bus.RespValid1) chk("rdata_idle", bus.RespReadData, 32'h0);
      chk("excl_mem",   32'(bus.MemRead & bus.MemWrite), 32'd0);
      chk("excl_ready", 32'(bus.ReqReady0 & bus.ReqReady1), 32'd0);
      chk("excl_resp",  32'(bus.RespValid0 & bus.RespValid1), 32'd0);
      chk("busy_mem",   32'((bus.MemRead | bus.MemWrite | bus.RespValid0 | bus.RespValid1) & ~bus.Busy), 32'd0);
    end
  end

  task automatic set_cmd(input int i, input logic w, input logic [5:0] a, input logic [31:0] d);
    rv[i] = 1'b1;
    rw[i] = w;
    ra[i] = a;
    rd[i] = d;
  endtask

  // One cycle: sample after the falling edge and log any acceptance
  task automatic tick();
    logic [1:0] rdy;
    @(negedge Clock);
    #1;
    rdy = {bus.ReqReady1, bus.ReqReady0};
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        push_exp(i);
        ready_cnt[i]++;
        ready_cyc[i] = cyc;
        order.push_back(i);
      end
    end
  endtask

  // Lone request with ready/response latency checks relative to the drive cycle
  task automatic single(input int i, input logic w, input logic [5:0] a, input logic [31:0] d);
    int c0, nr, ns;
    bit seen;
    @(posedge Clock);
    #1;
    set_cmd(i, w, a, d);
    c0 = cyc;
    nr = ready_cnt[i];
    ns = resp_cnt[i];
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (ready_cnt[i] != nr) seen = 1;
    end
    rv[i] = 1'b0;
    chk("ready_seen", 32'(seen), 32'd1);
    chk("ready_latency", 32'(ready_cyc[i] - c0), 32'd1);
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      tick();
      if (resp_cnt[i] != ns) seen = 1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    chk("resp_latency", 32'(resp_cyc[i] - c0), 32'd2);
  endtask

  int idle_cnt, idle_run, idle_max, ca, nr1, nv0, nv1, nrs0, nrs1;
  bit done0, done1;

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
      ready_cnt[i] = 0; ready_cyc[i] = 0; resp_cnt[i] = 0; resp_cyc[i] = 0;
    end

    // Reset values while ResetN is held low
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_grant",    32'(bus.Grant), 32'd0);
    chk("rst_busy",     32'(bus.Busy), 32'd0);
    chk("rst_memrd",    32'(bus.MemRead), 32'd0);
    chk("rst_memwr",    32'(bus.MemWrite), 32'd0);
    chk("rst_memaddr",  32'(bus.MemAddress), 32'd0);
    chk("rst_memwdata", bus.MemWriteData, 32'd0);
    chk("rst_rdata",    bus.RespReadData, 32'd0);
    chk("rst_ready",    32'({bus.ReqReady1, bus.ReqReady0}), 32'd0);
    chk("rst_resp",     32'({bus.RespValid1, bus.RespValid0}), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;

    // Write then read back from requester 0
    single(0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    single(0, 1'b0, 6'd5, 32'h0);
    tick();

    // Fresh reset, then simultaneous first requests: requester 0 must win the tie
    @(posedge Clock);
    #1;
    ResetN = 1'b0;
    #2;
    chk("rst2_grant", 32'(bus.Grant), 32'd0);
    chk("rst2_busy",  32'(bus.Busy), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    order.delete();
    @(posedge Clock);
    #1;
    set_cmd(0, 1'b0, 6'd1, 32'h0);
    set_cmd(1, 1'b0, 6'd2, 32'h0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.ReqReady0) rv[0] = 1'b0;
      if (bus.ReqReady1) rv[1] = 1'b0;
    end
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    chk("tie_count",  32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("tie_first",  32'(order[0]), 32'd0);
      chk("tie_second", 32'(order[1]), 32'd1);
    end
    chk("tie_resp_gap", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);

    // Continuous contention for 12 cycles; each requester reloads a new command on acceptance
    order.delete();
    idle_cnt = 0; idle_run = 0; idle_max = 0;
    @(posedge Clock);
    #1;
    set_cmd(0, 1'b1, 6'd16, $urandom);
    set_cmd(1, 1'b0, 6'd16, 32'h0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.ReqReady0) set_cmd(0, ~rw[0], ra[0] + 6'd1, $urandom);
      if (bus.ReqReady1) set_cmd(1, ~rw[1], ra[1], $urandom);
      if (!bus.Busy) begin
        idle_cnt++;
        idle_run++;
        if (idle_run > idle_max) idle_max = idle_run;
      end else begin
        idle_run = 0;
      end
    end
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    repeat (4) tick();
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < 4 && k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k % 2));
    chk("rr_idle_cycles", 32'(idle_cnt), 32'd4);
    chk("rr_idle_gap",    32'(idle_max), 32'd1);

    // Requester 1 raises its request while requester 0 is in ISSUE
    nr1 = ready_cnt[1];
    @(posedge Clock);
    #1;
    set_cmd(0, 1'b0, 6'd3, 32'h0);
    nv0 = ready_cnt[0];
    ca = -100;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready_cnt[0] != nv0 && rv[0]) begin
        rv[0] = 1'b0;
        ca = cyc;
        set_cmd(1, 1'b0, 6'd4, 32'h0);
      end
      if (bus.ReqReady1) rv[1] = 1'b0;
    end
    rv[1] = 1'b0;
    chk("mid_accept_once",  32'(ready_cnt[1] - nr1), 32'd1);
    chk("mid_accept_cycle", 32'(ready_cyc[1] - ca), 32'd3);

    // Write aborted by reset inside ISSUE must not reach memory or respond
    single(0, 1'b1, 6'd9, 32'hCAFE_F00D);
    tick();
    nv0 = ready_cnt[0];
    nv1 = ready_cnt[1];
    nrs0 = resp_cnt[0];
    nrs1 = resp_cnt[1];
    @(posedge Clock);
    #1;
    set_cmd(0, 1'b1, 6'd9, 32'h1234_5678);
    @(posedge Clock);
    #1;
    chk("abort_in_issue", 32'(bus.MemWrite), 32'd1);
    #1;
    ResetN = 1'b0;
    #1;
    chk("abort_memwr", 32'(bus.MemWrite), 32'd0);
    chk("abort_busy",  32'(bus.Busy), 32'd0);
    chk("abort_ready", 32'(bus.ReqReady0), 32'd0);
    rv[0] = 1'b0;
    #1;
    ResetN = 1'b1;
    repeat (4) tick();
    chk("abort_no_ready", 32'(ready_cnt[0] - nv0 + ready_cnt[1] - nv1), 32'd0);
    chk("abort_no_resp",  32'(resp_cnt[0] - nrs0 + resp_cnt[1] - nrs1), 32'd0);
    single(0, 1'b0, 6'd9, 32'h0);
    single(1, 1'b0, 6'd9, 32'h0);
    repeat (3) tick();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    done0 = 1;
    done1 = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
